// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline-stage types and default bundle widths.
// Imported by the skid stage, its interface and its counters.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int DATA_W_DEF = 32*5+15;
    localparam int CTRL_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Upstream/downstream handshake plus hazard controls of one stage.
// master = the surrounding pipeline, slave = the stage itself.
interface pipe_stage_skid_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic              stall;
    logic              flush;

    modport master (
        output in_valid, in_data, in_ctrl,
        output out_ready, stall, flush,
        input  in_ready, out_valid,
        input  out_data, out_ctrl
    );

    modport slave (
        input  in_valid, in_data, in_ctrl,
        input  out_ready, stall, flush,
        output in_ready, out_valid,
        output out_data, out_ctrl
    );

endinterface

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter used for stage performance statistics.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline register with one skid entry, registered in_ready,
// stall/flush hazard hooks and back-pressure/bubble counters.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                CTRL_W   = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0] NOP_CTRL = {CTRL_W{1'b0}},
    parameter int                CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stage_skid_if.slave bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    state_t            state_q, state_n;
    logic [DATA_W-1:0] head_d_q, head_d_n;
    logic [CTRL_W-1:0] head_c_q, head_c_n;
    logic [DATA_W-1:0] skid_d_q, skid_d_n;
    logic [CTRL_W-1:0] skid_c_q, skid_c_n;
    logic              in_ready_q;
    logic              out_valid;
    logic              in_xfer;
    logic              out_xfer;
    logic              stall_inc;
    logic              bubble_inc;

    assign out_valid = (state_q != EMPTY) && !bus.stall;
    assign in_xfer   = bus.in_valid && in_ready_q
                    && !bus.stall && !bus.flush;
    assign out_xfer  = out_valid && bus.out_ready && !bus.flush;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? head_d_q : '0;
    assign bus.out_ctrl  = out_valid ? head_c_q : NOP_CTRL;

    always_comb begin
        state_n  = state_q;
        head_d_n = head_d_q;
        head_c_n = head_c_q;
        skid_d_n = skid_d_q;
        skid_c_n = skid_c_q;
        if (bus.flush) begin
            state_n  = EMPTY;
            head_d_n = '0;
            head_c_n = NOP_CTRL;
            skid_d_n = '0;
            skid_c_n = NOP_CTRL;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_n  = HALF;
                        head_d_n = bus.in_data;
                        head_c_n = bus.in_ctrl;
                    end
                end
                HALF: begin
                    if (in_xfer && out_xfer) begin
                        head_d_n = bus.in_data;
                        head_c_n = bus.in_ctrl;
                    end else if (in_xfer) begin
                        state_n  = FULL;
                        skid_d_n = bus.in_data;
                        skid_c_n = bus.in_ctrl;
                    end else if (out_xfer) begin
                        state_n = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a drain can happen
                    if (out_xfer) begin
                        state_n  = HALF;
                        head_d_n = skid_d_q;
                        head_c_n = skid_c_q;
                        skid_d_n = '0;
                        skid_c_n = NOP_CTRL;
                    end
                end
                default: begin
                    state_n = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            head_d_q   <= '0;
            head_c_q   <= NOP_CTRL;
            skid_d_q   <= '0;
            skid_c_q   <= NOP_CTRL;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_n;
            head_d_q   <= head_d_n;
            head_c_q   <= head_c_n;
            skid_d_q   <= skid_d_n;
            skid_c_q   <= skid_c_n;
            in_ready_q <= (state_n != FULL);
        end
    end

    assign stall_inc  = (state_q != EMPTY)
                     && (bus.stall || !bus.out_ready)
                     && !bus.flush;
    assign bubble_inc = (state_q == EMPTY)
                     && bus.out_ready && !bus.stall;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a default-width stage and a
// narrow CNT_W=4 stage for counter saturation.
module tb_pipe_stage_skid;

    logic clk;
    logic rst;
    int   ncmp;
    int   nerr;

    localparam logic [15:0] NOP  = 16'hDEAD;
    localparam logic [3:0]  NOP4 = 4'h5;

    pipe_stage_skid_if #(.DATA_W(175), .CTRL_W(16)) bus ();
    pipe_stage_skid_if #(.DATA_W(8), .CTRL_W(4))    b4 ();

    logic [15:0] stall_cnt;
    logic [15:0] bubble_cnt;
    logic [3:0]  sc4;
    logic [3:0]  bc4;

    pipe_stage_skid #(
        .DATA_W   (175),
        .CTRL_W   (16),
        .NOP_CTRL (NOP),
        .CNT_W    (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    pipe_stage_skid #(
        .DATA_W   (8),
        .CTRL_W   (4),
        .NOP_CTRL (NOP4),
        .CNT_W    (4)
    ) dut4 (
        .clk        (clk),
        .rst        (rst),
        .bus        (b4),
        .stall_cnt  (sc4),
        .bubble_cnt (bc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [174:0] mk(int id);
        return {75'(id), 100'(id * 7 + 3)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_ctrl   = '0;
        bus.out_ready = 1'b0;
        bus.stall     = 1'b0;
        bus.flush     = 1'b0;
        b4.in_valid   = 1'b0;
        b4.in_data    = '0;
        b4.in_ctrl    = '0;
        b4.out_ready  = 1'b0;
        b4.stall      = 1'b0;
        b4.flush      = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (2) tick();
        ncmp++;
        if (bus.in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL rst_in_ready: got %0b want 1", bus.in_ready);
        end
        ncmp++;
        if (bus.out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL rst_out_valid: got %0b want 0", bus.out_valid);
        end
        ncmp++;
        if (bus.out_data !== 175'd0) begin
            nerr++;
            $display("FAIL rst_out_data: got %h want 0", bus.out_data);
        end
        ncmp++;
        if (bus.out_ctrl !== NOP) begin
            nerr++;
            $display("FAIL rst_out_ctrl: got %h want %h", bus.out_ctrl, NOP);
        end
        ncmp++;
        if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin
            nerr++;
            $display("FAIL rst_cnt: got %0d/%0d want 0/0",
                     stall_cnt, bubble_cnt);
        end
        ncmp++;
        if (b4.in_ready !== 1'b1 || b4.out_ctrl !== NOP4) begin
            nerr++;
            $display("FAIL rst_b4: got rdy %0b ctrl %h want 1 %h",
                     b4.in_ready, b4.out_ctrl, NOP4);
        end
        rst = 1'b0;
    endtask

    task automatic test_latency();
        do_reset();
        bus.in_valid  = 1'b1;
        bus.in_data   = 175'hA5;
        bus.in_ctrl   = 16'h0001;
        bus.out_ready = 1'b1;
        tick();
        ncmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 175'hA5) begin
            nerr++;
            $display("FAIL lat_out: got v%0b %h want v1 a5",
                     bus.out_valid, bus.out_data);
        end
        ncmp++;
        if (bus.out_ctrl !== 16'h0001) begin
            nerr++;
            $display("FAIL lat_ctrl: got %h want 0001", bus.out_ctrl);
        end
        ncmp++;
        if (bubble_cnt !== 16'd1) begin
            nerr++;
            $display("FAIL lat_bubble: got %0d want 1", bubble_cnt);
        end
        bus.in_valid = 1'b0;
        tick();
        ncmp++;
        if (bus.out_valid !== 1'b0 || bus.out_ctrl !== NOP) begin
            nerr++;
            $display("FAIL lat_drain: got v%0b ctrl %h want v0 %h",
                     bus.out_valid, bus.out_ctrl, NOP);
        end
        ncmp++;
        if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd1) begin
            nerr++;
            $display("FAIL lat_cnt: got %0d/%0d want 0/1",
                     stall_cnt, bubble_cnt);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_data  = mk(1);
        bus.in_ctrl  = 16'd1;
        tick();
        ncmp++;
        if (bus.out_data !== mk(1) || bus.in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL bp_first: got %h rdy %0b want %h rdy 1",
                     bus.out_data, bus.in_ready, mk(1));
        end
        bus.in_data = mk(2);
        bus.in_ctrl = 16'd2;
        tick();
        ncmp++;
        if (bus.in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL bp_full_rdy: got %0b want 0", bus.in_ready);
        end
        bus.in_data = mk(3);
        bus.in_ctrl = 16'd3;
        repeat (2) tick();
        ncmp++;
        if (bus.in_ready !== 1'b0 || bus.out_data !== mk(1)) begin
            nerr++;
            $display("FAIL bp_hold: got rdy %0b %h want rdy 0 %h",
                     bus.in_ready, bus.out_data, mk(1));
        end
        ncmp++;
        if (stall_cnt !== 16'd3) begin
            nerr++;
            $display("FAIL bp_stall_cnt: got %0d want 3", stall_cnt);
        end
        bus.out_ready = 1'b1;
        tick();
        ncmp++;
        if (bus.out_data !== mk(2) || bus.in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL bp_second: got %h rdy %0b want %h rdy 1",
                     bus.out_data, bus.in_ready, mk(2));
        end
        tick();
        ncmp++;
        if (bus.out_data !== mk(3) || bus.out_ctrl !== 16'd3) begin
            nerr++;
            $display("FAIL bp_third: got %h ctrl %h want %h ctrl 3",
                     bus.out_data, bus.out_ctrl, mk(3));
        end
        bus.in_valid = 1'b0;
        tick();
        ncmp++;
        if (bus.out_valid !== 1'b0 || stall_cnt !== 16'd3) begin
            nerr++;
            $display("FAIL bp_end: got v%0b cnt %0d want v0 cnt 3",
                     bus.out_valid, stall_cnt);
        end
    endtask

    task automatic test_stall();
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_data  = mk(7);
        bus.in_ctrl  = 16'd7;
        tick();
        bus.in_valid  = 1'b0;
        bus.stall     = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        ncmp++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 175'd0
            || bus.out_ctrl !== NOP) begin
            nerr++;
            $display("FAIL stall_out: got v%0b %h %h want v0 0 %h",
                     bus.out_valid, bus.out_data, bus.out_ctrl, NOP);
        end
        repeat (3) tick();
        bus.stall = 1'b0;
        #1;
        ncmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== mk(7)) begin
            nerr++;
            $display("FAIL stall_keep: got v%0b %h want v1 %h",
                     bus.out_valid, bus.out_data, mk(7));
        end
        ncmp++;
        if (stall_cnt !== 16'd3) begin
            nerr++;
            $display("FAIL stall_cnt: got %0d want 3", stall_cnt);
        end
        repeat (2) tick();
        ncmp++;
        if (bus.out_valid !== 1'b0 || bubble_cnt !== 16'd1) begin
            nerr++;
            $display("FAIL stall_bubble: got v%0b bub %0d want v0 bub 1",
                     bus.out_valid, bubble_cnt);
        end
    endtask

    task automatic test_flush();
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_data  = mk(11);
        bus.in_ctrl  = 16'd11;
        tick();
        bus.in_data = mk(12);
        bus.in_ctrl = 16'd12;
        tick();
        ncmp++;
        if (bus.in_ready !== 1'b0 || stall_cnt !== 16'd1) begin
            nerr++;
            $display("FAIL flush_pre: got rdy %0b cnt %0d want rdy 0 cnt 1",
                     bus.in_ready, stall_cnt);
        end
        bus.in_data = mk(13);
        bus.stall   = 1'b1;
        bus.flush   = 1'b1;
        tick();
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        ncmp++;
        if (bus.out_valid !== 1'b0 || bus.out_ctrl !== NOP) begin
            nerr++;
            $display("FAIL flush_out: got v%0b ctrl %h want v0 %h",
                     bus.out_valid, bus.out_ctrl, NOP);
        end
        ncmp++;
        if (bus.in_ready !== 1'b1 || stall_cnt !== 16'd1) begin
            nerr++;
            $display("FAIL flush_rdy_cnt: got rdy %0b cnt %0d want 1 1",
                     bus.in_ready, stall_cnt);
        end
    endtask

    task automatic test_stream();
        int sent;
        int recv;
        int occ;
        int bp;
        int verr;
        int cyc;
        do_reset();
        sent = 0;
        recv = 0;
        bp   = 0;
        verr = 0;
        cyc  = 0;
        while (recv < 100 && cyc < 3000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
            bus.in_data   = mk(sent + 1);
            bus.in_ctrl   = 16'(sent + 1);
            #1;
            occ = sent - recv;
            if (bus.out_valid !== (occ > 0)) verr++;
            if (bus.in_ready !== (occ != 2)) verr++;
            if (occ > 0 && !bus.out_ready) bp++;
            if (bus.out_valid && bus.out_ready) begin
                ncmp++;
                if (bus.out_data !== mk(recv + 1)
                    || bus.out_ctrl !== 16'(recv + 1)) begin
                    nerr++;
                    $display("FAIL stream_order: got %h ctrl %h want %h",
                             bus.out_data, bus.out_ctrl, mk(recv + 1));
                end
                recv++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            tick();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        ncmp++;
        if (recv !== 100) begin
            nerr++;
            $display("FAIL stream_count: got %0d want 100", recv);
        end
        ncmp++;
        if (verr !== 0) begin
            nerr++;
            $display("FAIL stream_flags: got %0d bad cycles want 0", verr);
        end
        ncmp++;
        if (stall_cnt !== 16'(bp)) begin
            nerr++;
            $display("FAIL stream_stall_cnt: got %0d want %0d",
                     stall_cnt, bp);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        b4.in_valid = 1'b1;
        b4.in_data  = 8'h3C;
        b4.in_ctrl  = 4'h2;
        tick();
        b4.in_valid = 1'b0;
        repeat (14) tick();
        ncmp++;
        if (sc4 !== 4'd14) begin
            nerr++;
            $display("FAIL sat_mid: got %0d want 14", sc4);
        end
        repeat (6) tick();
        ncmp++;
        if (sc4 !== 4'd15) begin
            nerr++;
            $display("FAIL sat_top: got %0d want 15", sc4);
        end
        ncmp++;
        if (b4.out_valid !== 1'b1 || b4.out_data !== 8'h3C) begin
            nerr++;
            $display("FAIL sat_hold: got v%0b %h want v1 3c",
                     b4.out_valid, b4.out_data);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_data  = mk(4);
        bus.in_ctrl  = 16'd4;
        tick();
        bus.in_data = mk(5);
        bus.in_ctrl = 16'd5;
        tick();
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        ncmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL arst_flags: got v%0b rdy %0b want v0 rdy 1",
                     bus.out_valid, bus.in_ready);
        end
        ncmp++;
        if (bus.out_data !== 175'd0 || bus.out_ctrl !== NOP
            || stall_cnt !== 16'd0) begin
            nerr++;
            $display("FAIL arst_data: got %h %h cnt %0d want 0 %h 0",
                     bus.out_data, bus.out_ctrl, stall_cnt, NOP);
        end
        #2;
        rst = 1'b0;
        tick();
        bus.in_valid  = 1'b1;
        bus.in_data   = mk(9);
        bus.in_ctrl   = 16'd9;
        bus.out_ready = 1'b1;
        tick();
        ncmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== mk(9)) begin
            nerr++;
            $display("FAIL arst_after: got v%0b %h want v1 %h",
                     bus.out_valid, bus.out_data, mk(9));
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    initial begin
        ncmp = 0;
        nerr = 0;
        rst  = 1'b1;
        idle();
        test_reset();
        test_latency();
        test_backpressure();
        test_stall();
        test_flush();
        test_stream();
        test_saturate();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 32*5+15 (=175), meaning the packed payload width; pass through unmodified.
REQ-002 Parameter CTRL_W, default 16, meaning the packed control-bundle width.
REQ-003 Parameter NOP_CTRL, default {CTRL_W{1'b0}}, meaning the control word presented whenever out_valid=0.
REQ-004 Parameter CNT_W, default 16, meaning the width of each performance counter.
REQ-005 clk input 1 is the single clock; all state updates on posedge clk.
REQ-006 rst input 1 is the reset, asynchronous and active-high.
REQ-007 in_valid input 1 signals that the upstream stage offers a transfer.
REQ-008 in_ready output 1 is registered and signals that the stage accepts this cycle.
REQ-009 in_data input DATA_W and in_ctrl input CTRL_W carry the upstream payload and control.
REQ-010 out_valid output 1 signals that the stage presents a valid entry.
REQ-011 out_ready input 1 signals that the downstream stage accepts.
REQ-012 out_data output DATA_W and out_ctrl output CTRL_W carry the head entry payload and control.
REQ-013 stall input 1 is a hazard-unit hold that freezes both sides.
REQ-014 flush input 1 is a hazard-unit squash of all held entries.
REQ-015 stall_cnt output CNT_W counts back-pressure cycles; bubble_cnt output CNT_W counts empty-issue cycles.

Function
REQ-016 Storage: main register (head) plus one skid register; states EMPTY (0 entries), HALF (head valid), FULL (head+skid valid).
REQ-017 Input transfer = in_valid & in_ready & !stall & !flush; output transfer = out_valid & out_ready & !stall & !flush.
REQ-018 out_valid = (state != EMPTY) & !stall; out_data/out_ctrl = head when out_valid=1, else 0 / NOP_CTRL.
REQ-019 in_ready next = (next state != FULL); in_ready never depends combinationally on out_ready.
REQ-020 Latency: in_data accepted at edge N appears on out_data in cycle N+1 when the stage was EMPTY.
REQ-021 EMPTY: in-transfer -> HALF, head<=in; otherwise stay.
REQ-022 HALF: in-transfer & out-transfer -> HALF, head<=in; in-transfer only -> FULL, skid<=in; out-transfer only -> EMPTY; neither -> stay.
REQ-023 FULL: out-transfer -> HALF, head<=skid; no in-transfer is possible (in_ready=0).
REQ-024 Order preserved: entries leave in exactly acceptance order; no entry is duplicated or dropped except by flush.
REQ-025 stall=1: no transfer either side, state and storage held, in_ready held at its registered value.
REQ-026 flush=1: next state EMPTY, head/skid cleared to 0/NOP_CTRL, a concurrent in_valid is discarded; flush has priority over stall.
REQ-027 stall_cnt increments by 1 per cycle when (state != EMPTY) & (stall | !out_ready) & !flush; saturates at all-ones.
REQ-028 bubble_cnt increments by 1 per cycle when state == EMPTY & out_ready & !stall; saturates at all-ones.
REQ-029 Counters are never cleared by flush.

Reset
REQ-030 rst=1 asynchronously forces: state EMPTY, in_ready=1, out_valid=0, head/skid and out_data=0, out_ctrl=NOP_CTRL, stall_cnt=0, bubble_cnt=0.
REQ-031 Reset asserted mid-transfer discards all held entries; the first accepting edge after deassertion behaves as EMPTY.

Structure
REQ-032 State enum (EMPTY/HALF/FULL) and the default control-bundle width constant belong in the shared package pipe_pkg.
REQ-033 The saturating counter is a sub-module sat_counter (params CNT_W; ports clk, rst, inc, count), instantiated twice.
REQ-034 The block is intended to replace every fixed DEC/EXE/MEM/WB pipeline register via parameters alone.

Verification
REQ-035 Reset, then in_valid=1 in_data=0xA5 out_ready=1 -> out_valid=1 and out_data=0xA5 in the next cycle; state HALF.
REQ-036 Hold out_ready=0, offer entries 1,2,3 -> 1 and 2 accepted, in_ready=0 from the cycle after 2 is accepted, 3 held upstream; raise out_ready -> 1,2,3 emerge in order.
REQ-037 With stage FULL, assert stall and flush together for 1 cycle -> next cycle out_valid=0, out_ctrl=NOP_CTRL, in_ready=1, stall_cnt unchanged by that cycle.
REQ-038 Stream 100 entries with random out_ready at 50% -> the scoreboard shows in-order, lossless delivery and the stall_cnt value equals the number of back-pressure cycles counted by the bench.
REQ-039 CNT_W=4, keep out_ready=0 with stage HALF for 20 cycles -> stall_cnt saturates at 15.
REQ-040 Assert rst asynchronously between edges while FULL -> outputs reach reset values before the next edge.
